// File: rtl/ecc_sed_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ecc_sed_decoder
// Description : Single-error-detect parity checker with one registered
//               valid/ready output stage and saturating error statistics.
//               Optional build macro ECC_SED_DROP_ERR_EN consumes errored
//               words without forwarding them.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_sed_decoder #(
    parameter int DATA_W     = 12,
    parameter bit ODD_PARITY = 1'b1,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic [DATA_W:0]   enc_codeword,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] data,
    output logic              dec_err,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count,
    input  logic              clr
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic              w_syn;
    logic              w_err;
    logic              w_accept;
    logic              w_fwd;

    logic              r_dec_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_err_sticky;
    logic [CNT_W-1:0]  r_err_count;

    assign w_syn     = ^enc_codeword;
    assign w_err     = ODD_PARITY ? ~w_syn : w_syn;
    assign enc_ready = !r_dec_valid || dec_ready;
    assign w_accept  = enc_valid && enc_ready;

`ifdef ECC_SED_DROP_ERR_EN
    // Errored words are swallowed: accepted upstream, never presented downstream.
    assign w_fwd = w_accept && !w_err;
`else
    assign w_fwd = w_accept;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dec_valid <= 1'b0;
            r_data      <= '0;
        end else if (w_fwd) begin
            r_dec_valid <= 1'b1;
            r_data      <= enc_codeword[DATA_W-1:0];
        end else if (dec_ready) begin
            r_dec_valid <= 1'b0;
        end
    end

`ifdef ECC_SED_DROP_ERR_EN
    assign dec_err = 1'b0;
`else
    logic r_dec_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dec_err <= 1'b0;
        end else if (w_fwd) begin
            r_dec_err <= w_err;
        end
    end

    assign dec_err = r_dec_err;
`endif

    // clr has priority over a coincident errored word, which is then not counted.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (w_accept && w_err) begin
            r_err_sticky <= 1'b1;
            if (r_err_count != c_CNT_MAX) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign dec_valid  = r_dec_valid;
    assign data       = r_data;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire
